mips_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It sits directly upstream of the ID stage and consumes the hazard unit's `PCWrite` / `IF_IDWrite` to freeze fetch on load-use stalls. It also applies branch/jump redirects, which flush the wrong-path IF/ID entry. Two saturating performance counters record stall and flush cycles.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_if_id_reg.sv | 51 +++++
 rtl/mips_fetch_stage.sv | 84 ++++++++
 tb/tb_mips_fetch_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and small helpers.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_if_id_reg.sv
// IF/ID pipeline register: flush beats enable, enable beats hold.
module mips_if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_next,
  input  logic [ADDR_W-1:0]  pc4_next,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = instr_next;
      pc4_d   = pc4_next;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, redirect/stall handling, IF/ID
// register and saturating stall/flush counters.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCWrite,
  input  logic               IF_IDWrite,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic               JumpTaken,
  input  logic [ADDR_W-1:0]  JumpTarget,
  output logic [ADDR_W-1:0]  ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [ADDR_W-1:0]  IF_ID_PC4,
  output logic               IF_ID_Valid,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  assign redirect = BranchTaken | JumpTaken;
  // The branch in EX is older than the jump in ID, so it wins.
  assign target   = word_align(BranchTaken ? BranchTarget : JumpTarget);
  assign pc_plus4 = pc_q + 32'd4;
  assign stall    = !redirect && (!PCWrite || !IF_IDWrite);

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target;
    end else if (PCWrite) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  mips_if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .en         (IF_IDWrite),
    .flush      (redirect),
    .instr_next (ImemData),
    .pc4_next   (pc_plus4),
    .instr      (IF_ID_Instr),
    .pc4        (IF_ID_PC4),
    .valid      (IF_ID_Valid)
  );

  assign ImemAddr   = pc_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus random
// traffic compared against a behavioural model of the fetch stage.
module tb_mips_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_IDWrite;
  logic        BranchTaken, JumpTaken;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] ImemAddr, ImemData;
  logic [31:0] IF_ID_Instr, IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [15:0] StallCount, FlushCount;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign ImemData = imem_word(ImemAddr);

  mips_fetch_stage #(
    .RESET_PC (RST_PC),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IF_IDWrite   (IF_IDWrite),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .JumpTaken    (JumpTaken),
    .JumpTarget   (JumpTarget),
    .ImemAddr     (ImemAddr),
    .ImemData     (ImemData),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Valid  (IF_ID_Valid),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    ImemAddr,           m_pc);
    check({tag, ".instr"}, IF_ID_Instr,        m_instr);
    check({tag, ".pc4"},   IF_ID_PC4,          m_pc4);
    check({tag, ".valid"}, {31'b0, IF_ID_Valid}, {31'b0, m_valid});
    check({tag, ".stall"}, {16'b0, StallCount}, m_stall);
    check({tag, ".flush"}, {16'b0, FlushCount}, m_flush);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock edge: advance the model from current inputs, then compare.
  task automatic step(input string tag, input bit do_check);
    logic [31:0] tgt, fetched;
    bit          redir;
    redir   = BranchTaken || JumpTaken;
    tgt     = BranchTaken ? BranchTarget : JumpTarget;
    tgt     = tgt & 32'hFFFF_FFFC;
    fetched = imem_word(m_pc);
    if (redir) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (IF_IDWrite) begin
      m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1;
    end
    if (redir) m_pc = tgt;
    else if (PCWrite) m_pc = m_pc + 32'd4;
    if (redir && m_flush < 65535) m_flush++;
    if (!redir && (!PCWrite || !IF_IDWrite) && m_stall < 65535) m_stall++;
    @(posedge clk);
    #1;
    if (do_check) check_model(tag);
  endtask

  task automatic set_in(input bit pcw, input bit ifw, input bit bt, input logic [31:0] btg,
                        input bit jt, input logic [31:0] jtg);
    PCWrite = pcw; IF_IDWrite = ifw;
    BranchTaken = bt; BranchTarget = btg;
    JumpTaken = jt; JumpTarget = jtg;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 1, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    // Reset release: first edge captures the word at RESET_PC
    check("release.addr", ImemAddr, 32'h0040_0000);
    step("release", 1);
    check("release.instr", IF_ID_Instr, 32'h2008_0005);
    check("release.pc4", IF_ID_PC4, 32'h0040_0004);

    // Load-use stall at PC 0x10
    set_in(1, 1, 0, 0, 1, 32'h0000_0010);
    step("jmp10", 1);
    set_in(0, 0, 0, 0, 0, 0);
    step("stall", 1);
    check("stall.pc", ImemAddr, 32'h0000_0010);
    check("stall.cnt", {16'b0, StallCount}, 32'd1);
    set_in(1, 1, 0, 0, 0, 0);
    step("unstall", 1);
    check("unstall.pc", ImemAddr, 32'h0000_0014);

    // Branch wins over a held PC
    set_in(0, 1, 1, 32'h0000_0103, 0, 0);
    step("br_stall", 1);
    check("br_stall.pc", ImemAddr, 32'h0000_0100);
    check("br_stall.valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("br_stall.cnt", {16'b0, StallCount}, 32'd1);

    // Branch and jump together
    set_in(1, 1, 1, 32'h0000_0200, 1, 32'h0000_0300);
    step("br_jmp", 1);
    check("br_jmp.pc", ImemAddr, 32'h0000_0200);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0, $urandom);
      step("rand", 1);
    end

    // PC wrap
    set_in(1, 1, 0, 0, 1, 32'hFFFF_FFFC);
    step("jmp_top", 1);
    set_in(1, 1, 0, 0, 0, 0);
    step("wrap", 1);
    check("wrap.pc", ImemAddr, 32'h0000_0000);
    check("wrap.pc4", IF_ID_PC4, 32'h0000_0000);

    // Stall saturation
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step("sat", 0);
    check_model("sat");
    check("sat.cnt", {16'b0, StallCount}, 32'h0000_FFFF);
    step("sat_hold", 1);

    // Async reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("areset.stall", {16'b0, StallCount}, 32'd0);
    check("areset.flush", {16'b0, FlushCount}, 32'd0);
    check("areset.instr", IF_ID_Instr, 32'd0);
    check("areset.pc4", IF_ID_PC4, 32'd0);
    check("areset.valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("areset.pc", ImemAddr, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
